// File: rtl/ula_alu.sv
// Purpose : integer ALU for the single-cycle MIPS datapath (add, sub, and, or, signed slt).
// Latency : one clock; result and flags are registered together on the rising clk edge.
// Backpressure: none; new operands are accepted every cycle and outputs hold between edges.
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   rst_n      - synchronous active-low reset (ALUResult=0, Zero=1, Overflow=0)
//   A, B       - operands (rs, rt/immediate), WIDTH bits
//   ALUControl - operation select: 000 add, 001 sub, 010 and, 011 or, 101 slt, others -> 0
//   ALUResult  - registered result
//   Zero       - registered, high when ALUResult is all zeros
//   Overflow   - registered signed overflow of add/sub, low for every other code
module ula_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Overflow
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_RSV4 = 3'b100,
        OP_SLT  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } alu_op_t;

    // Everything that is registered at the edge travels as one bundle so the
    // flags can never drift out of step with the result they describe.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             overflow;
    } alu_out_t;

    alu_op_t    op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt_bit;
    alu_out_t         nxt;
    alu_out_t         cur;

    assign op = alu_op_t'(ALUControl);

    // Both arithmetic paths are always computed; sub is reused by slt.
    assign sum  = A + B;
    assign diff = A - B;

    // Add overflows when the operands agree in sign and the sum disagrees.
    assign add_ovf = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
    // Sub overflows when the operands differ in sign and the difference's
    // sign departs from A.
    assign sub_ovf = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);

    // The raw sign of A-B lies exactly when the subtraction overflows, so
    // flipping it by the overflow bit gives the true signed A < B.
    assign slt_bit = diff[MSB] ^ sub_ovf;

    always_comb begin
        nxt.result   = '0;
        nxt.overflow = 1'b0;
        case (op)
            OP_ADD: begin
                nxt.result   = sum;
                nxt.overflow = add_ovf;
            end
            OP_SUB: begin
                nxt.result   = diff;
                nxt.overflow = sub_ovf;
            end
            OP_AND:  nxt.result = A & B;
            OP_OR:   nxt.result = A | B;
            OP_SLT:  nxt.result = {{(WIDTH-1){1'b0}}, slt_bit};
            default: begin
                nxt.result   = '0;
                nxt.overflow = 1'b0;
            end
        endcase
        // Zero is derived from the value about to be registered, which keeps
        // Zero == (ALUResult == 0) true after every edge, reset included.
        nxt.zero = (nxt.result == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur.result   <= '0;
            cur.zero     <= 1'b1;
            cur.overflow <= 1'b0;
        end else begin
            cur <= nxt;
        end
    end

    assign ALUResult = cur.result;
    assign Zero      = cur.zero;
    assign Overflow  = cur.overflow;

endmodule

// File: tb/tb_ula_alu.sv
// Purpose : self-checking bench for ula_alu (WIDTH=32) against an arithmetic reference model.
// Latency : each step drives inputs at negedge and checks one rising edge later.
// Backpressure: none; steps are issued back-to-back every cycle.
module tb_ula_alu;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   ALUControl;
    logic [W-1:0] ALUResult;
    logic         Zero;
    logic         Overflow;

    int checks   = 0;
    int failures = 0;

    ula_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Overflow   (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: works on the operands as mathematical signed integers
    // in 64-bit arithmetic and reduces modulo 2^32 only at the end.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] op,
                                  output logic [W-1:0] r, output logic ov);
        longint sa;
        longint sb;
        longint t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        t  = 0;
        r  = '0;
        ov = 1'b0;
        case (op)
            3'd0: begin
                t  = sa + sb;
                r  = t[W-1:0];
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd1: begin
                t  = sa - sb;
                r  = t[W-1:0];
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            default: begin
                r  = '0;
                ov = 1'b0;
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check just after the rising edge, then
    // scramble the inputs and confirm the registered outputs hold.
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic rst, input string tag);
        logic [W-1:0] er;
        logic         eo;
        logic         ez;
        @(negedge clk);
        A          = a;
        B          = b;
        ALUControl = op;
        rst_n      = ~rst;
        if (rst) begin
            er = '0;
            eo = 1'b0;
        end else begin
            model(a, b, op, er, eo);
        end
        ez = (er == '0);
        @(posedge clk);
        #1;
        chk({tag, "_result"},   ALUResult,        er);
        chk({tag, "_zero"},     {31'd0, Zero},     {31'd0, ez});
        chk({tag, "_overflow"}, {31'd0, Overflow}, {31'd0, eo});
        A          = $urandom;
        B          = $urandom;
        ALUControl = 3'($urandom_range(0, 7));
        rst_n      = 1'($urandom_range(0, 1));
        #2;
        chk({tag, "_hold"}, ALUResult, er);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h7FFF_FFFF;
            1:       v = 32'h8000_0000;
            2:       v = 32'($urandom_range(0, 3));
            3:       v = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        rst_n      = 1'b0;
        A          = '0;
        B          = '0;
        ALUControl = 3'd0;

        // Reset held for two edges, then released.
        step(32'd5, 32'd3, 3'b000, 1'b1, "rst0");
        step(32'd5, 32'd3, 3'b000, 1'b1, "rst1");
        step(32'd5, 32'd3, 3'b000, 1'b0, "rst_release");
        chk("rst_release_eight", ALUResult, 32'd8);

        // Add / sub, including both overflow directions.
        step(32'd10, 32'd5, 3'b000, 1'b0, "add_basic");
        chk("add_basic_15", ALUResult, 32'd15);
        step(32'd15, 32'd15, 3'b001, 1'b0, "sub_zero");
        chk("sub_zero_flag", {31'd0, Zero}, 32'd1);
        step(32'h7FFF_FFFF, 32'd1, 3'b000, 1'b0, "add_ovf");
        chk("add_ovf_flag", {31'd0, Overflow}, 32'd1);
        step(32'h8000_0000, 32'd1, 3'b001, 1'b0, "sub_ovf");
        chk("sub_ovf_val", ALUResult, 32'h7FFF_FFFF);

        // Logic ops.
        step(32'hFF00_FF00, 32'h0F0F_0F0F, 3'b010, 1'b0, "and");
        chk("and_val", ALUResult, 32'h0F00_0F00);
        step(32'h0000_FFFF, 32'hFFFF_0000, 3'b011, 1'b0, "or");
        chk("or_val", ALUResult, 32'hFFFF_FFFF);

        // Signed set-less-than, including the case where A-B overflows.
        step(32'd7, 32'd20, 3'b101, 1'b0, "slt_lt");
        chk("slt_lt_one", ALUResult, 32'd1);
        step(32'd25, 32'd10, 3'b101, 1'b0, "slt_ge");
        chk("slt_ge_zero", {31'd0, Zero}, 32'd1);
        step(32'hFFFF_FFFF, 32'd1, 3'b101, 1'b0, "slt_neg");
        chk("slt_neg_one", ALUResult, 32'd1);
        step(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1'b0, "slt_ovf");
        chk("slt_ovf_one", ALUResult, 32'd1);
        chk("slt_ovf_noflag", {31'd0, Overflow}, 32'd0);

        // Undefined opcodes.
        step(32'd100, 32'd50, 3'b100, 1'b0, "undef4");
        step(32'd100, 32'd50, 3'b110, 1'b0, "undef6");
        step(32'd100, 32'd50, 3'b111, 1'b0, "undef7");
        chk("undef7_zero", {31'd0, Zero}, 32'd1);

        // Back-to-back stream with a reset in the middle.
        step(32'd1, 32'd2, 3'b000, 1'b0, "b2b0");
        step(32'd9, 32'd4, 3'b001, 1'b0, "b2b1");
        step(32'h0000_00F0, 32'h0000_0FF0, 3'b010, 1'b0, "b2b2");
        step(32'd6, 32'd6, 3'b000, 1'b1, "b2b_rst");
        step(32'd3, 32'd8, 3'b101, 1'b0, "b2b3");
        step(32'd40, 32'd2, 3'b000, 1'b0, "b2b4");

        // Randomized stream against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic [2:0]   rop;
            logic         rr;
            ra  = pick_operand();
            rb  = ($urandom_range(0, 7) == 0) ? ra : pick_operand();
            rop = 3'($urandom_range(0, 7));
            rr  = ($urandom_range(0, 19) == 0);
            step(ra, rb, rop, rr, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
